// File: rtl/frame_sequencer_if.sv
// Sample-stream and run-control bundle for frame_sequencer.
// master drives stimulus and commands; slave is the sequencer itself.
interface frame_sequencer_if #(
  parameter int unsigned INPUT_DATA_WIDTH = 16,
  parameter int unsigned INPUT_ELEMENTS   = 4,
  parameter int unsigned FRAME_CNT_WIDTH  = 16
);
  localparam int unsigned DataWidth = INPUT_ELEMENTS * 2 * INPUT_DATA_WIDTH;

  logic                       enable;
  logic                       start;
  logic                       stop;
  logic [FRAME_CNT_WIDTH-1:0] num_frames;
  logic                       in_valid;
  logic [DataWidth-1:0]       in_data;
  logic                       out_valid;
  logic [DataWidth-1:0]       out_data;
  logic                       out_sof;
  logic                       out_eof;
  logic [FRAME_CNT_WIDTH-1:0] frame_counter;
  logic                       busy;
  logic                       done;

  modport master (
    output enable, start, stop, num_frames, in_valid, in_data,
    input  out_valid, out_data, out_sof, out_eof, frame_counter, busy, done
  );

  modport slave (
    input  enable, start, stop, num_frames, in_valid, in_data,
    output out_valid, out_data, out_sof, out_eof, frame_counter, busy, done
  );
endinterface

// File: rtl/frame_sequencer.sv
// Carves a continuous sample stream into fixed-size frames, forwards the leading
// DESIRED_FRAME_SIZE samples of each frame and runs for N frames or until stopped.
module frame_sequencer #(
  parameter int unsigned FRAME_SIZE         = 2048,
  parameter int unsigned DESIRED_FRAME_SIZE = 2000,
  parameter int unsigned SKIP_FRAME_SAMPLES = 48,
  parameter int unsigned INPUT_DATA_WIDTH   = 16,
  parameter int unsigned INPUT_ELEMENTS     = 4,
  parameter int unsigned FRAME_CNT_WIDTH    = 16
) (
  input logic               clk,
  input logic               reset,
  frame_sequencer_if.slave  bus
);

  localparam int unsigned DataWidth = INPUT_ELEMENTS * 2 * INPUT_DATA_WIDTH;
  localparam int unsigned CntWidth  = (FRAME_SIZE > 2) ? $clog2(FRAME_SIZE) : 1;
  localparam logic [CntWidth-1:0] LastPass  = CntWidth'(DESIRED_FRAME_SIZE - 1);
  localparam logic [CntWidth-1:0] LastFrame = CntWidth'(FRAME_SIZE - 1);
  localparam bit NoSkip = (SKIP_FRAME_SAMPLES == 0);

  if ((FRAME_SIZE != DESIRED_FRAME_SIZE + SKIP_FRAME_SAMPLES) || (DESIRED_FRAME_SIZE < 1) ||
      (FRAME_SIZE < 2)) begin : g_param_check
    $fatal(1, "frame_sequencer: inconsistent frame size parameters");
  end

  typedef enum logic [1:0] {StIdle, StPass, StSkip, StDone} state_e;

  state_e                     state_q, state_d;
  logic [CntWidth-1:0]        sample_cnt_q, sample_cnt_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [FRAME_CNT_WIDTH-1:0] num_frames_q, num_frames_d;
  logic                       stop_pending_q, stop_pending_d;
  logic                       out_valid_q, out_valid_d;
  logic [DataWidth-1:0]       out_data_q, out_data_d;
  logic                       out_sof_q, out_sof_d;
  logic                       out_eof_q, out_eof_d;

  logic                       accept;
  logic                       pass_last;
  logic                       frame_end;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_inc;
  logic                       run_over;

  assign accept        = bus.in_valid & bus.enable;
  assign pass_last     = (sample_cnt_q == LastPass);
  assign frame_end     = accept && (((state_q == StPass) && pass_last && NoSkip) ||
                                    ((state_q == StSkip) && (sample_cnt_q == LastFrame)));
  assign frame_cnt_inc = frame_cnt_q + FRAME_CNT_WIDTH'(1);
  // A stop raised on this very clock only takes effect at the following boundary.
  assign run_over      = stop_pending_q ||
                         ((num_frames_q != '0) && (frame_cnt_inc == num_frames_q));

  always_comb begin
    state_d        = state_q;
    sample_cnt_d   = sample_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    num_frames_d   = num_frames_q;
    stop_pending_d = stop_pending_q;
    out_valid_d    = 1'b0;
    out_data_d     = '0;
    out_sof_d      = 1'b0;
    out_eof_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && bus.enable) begin
          num_frames_d   = bus.num_frames;
          sample_cnt_d   = '0;
          frame_cnt_d    = '0;
          stop_pending_d = 1'b0;
          state_d        = StPass;
        end
      end
      StPass: begin
        if (bus.stop) stop_pending_d = 1'b1;
        if (accept) begin
          out_valid_d  = 1'b1;
          out_data_d   = bus.in_data;
          out_sof_d    = (sample_cnt_q == '0);
          out_eof_d    = pass_last;
          sample_cnt_d = sample_cnt_q + CntWidth'(1);
          if (pass_last) state_d = StSkip;
        end
      end
      StSkip: begin
        if (bus.stop) stop_pending_d = 1'b1;
        if (accept) sample_cnt_d = sample_cnt_q + CntWidth'(1);
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Frame boundary overrides the per-state counter/state updates above.
    if (frame_end) begin
      frame_cnt_d  = frame_cnt_inc;
      sample_cnt_d = '0;
      state_d      = run_over ? StDone : StPass;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      sample_cnt_q   <= '0;
      frame_cnt_q    <= '0;
      num_frames_q   <= '0;
      stop_pending_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_sof_q      <= 1'b0;
      out_eof_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_cnt_q   <= sample_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      num_frames_q   <= num_frames_d;
      stop_pending_q <= stop_pending_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_sof_q      <= out_sof_d;
      out_eof_q      <= out_eof_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_sof       = out_sof_q;
  assign bus.out_eof       = out_eof_q;
  assign bus.frame_counter = frame_cnt_q;
  assign bus.busy          = (state_q == StPass) || (state_q == StSkip);
  assign bus.done          = (state_q == StDone);

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed runs on the default geometry, a vector table on a
// 4-sample/no-skip instance and a randomized run against a frame-arithmetic reference model.
module tb_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int   n_vec = 0;
  int   n_bad = 0;

  frame_sequencer_if #(.INPUT_DATA_WIDTH(16), .INPUT_ELEMENTS(4), .FRAME_CNT_WIDTH(16)) if_a ();
  frame_sequencer_if #(.INPUT_DATA_WIDTH(8),  .INPUT_ELEMENTS(1), .FRAME_CNT_WIDTH(2))  if_b ();
  frame_sequencer_if #(.INPUT_DATA_WIDTH(4),  .INPUT_ELEMENTS(2), .FRAME_CNT_WIDTH(3))  if_c ();

  frame_sequencer u_a (.clk(clk), .reset(rst_a), .bus(if_a));

  frame_sequencer #(
    .FRAME_SIZE(4), .DESIRED_FRAME_SIZE(4), .SKIP_FRAME_SAMPLES(0),
    .INPUT_DATA_WIDTH(8), .INPUT_ELEMENTS(1), .FRAME_CNT_WIDTH(2)
  ) u_b (.clk(clk), .reset(rst_b), .bus(if_b));

  frame_sequencer #(
    .FRAME_SIZE(5), .DESIRED_FRAME_SIZE(3), .SKIP_FRAME_SAMPLES(2),
    .INPUT_DATA_WIDTH(4), .INPUT_ELEMENTS(2), .FRAME_CNT_WIDTH(3)
  ) u_c (.clk(clk), .reset(rst_c), .bus(if_c));

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- default-geometry stream monitor ----------------
  bit a_mon = 1'b0;
  int a_k   = 0;
  int a_exp_idx;
  always @(posedge clk) begin
    #1;
    if (a_mon) begin
      if (if_a.out_valid) begin
        a_exp_idx = (a_k / 2000) * 2048 + (a_k % 2000);
        check("a_data", if_a.out_data, a_exp_idx);
        check("a_sof", if_a.out_sof, (a_k % 2000) == 0);
        check("a_eof", if_a.out_eof, (a_k % 2000) == 1999);
        a_k++;
      end else begin
        check("a_data_idle_zero", if_a.out_data, 0);
      end
    end
  end

  task automatic a_run(input int nf, input int n_present, input int stop_idx, input bit stretch,
                       input int reset_idx, output int done_cnt, output int done_at);
    int  idx = 0;
    int  gap = 0;
    bit  tog = 1'b1;
    bit  stop_sent = 1'b0;
    bit  start2_sent = 1'b0;
    logic en, iv;
    done_cnt = 0;
    done_at  = -1;
    a_k = 0;
    // start and stop together in IDLE: stop must be ignored
    if_a.enable = 1'b1; if_a.start = 1'b1; if_a.stop = 1'b1;
    if_a.num_frames = 16'(nf); if_a.in_valid = 1'b0;
    @(posedge clk); #1;
    check("a_busy_after_start", if_a.busy, 1'b1);
    #1; if_a.start = 1'b0; if_a.stop = 1'b0;
    while (idx < n_present) begin
      if (idx == reset_idx) begin
        #1 rst_a = 1'b1;
        #1;
        check("a_async_reset_zero", {if_a.out_valid, if_a.out_sof, if_a.out_eof, if_a.busy,
              if_a.done, if_a.frame_counter, if_a.out_data}, 0);
        return;
      end
      en = 1'b1; iv = 1'b1;
      if (stretch && idx == 1500 && gap < 10) begin
        en = 1'b0; gap++;
      end else if (stretch && idx > 1500) begin
        iv = tog; tog = ~tog;
      end
      if_a.enable = en; if_a.in_valid = iv; if_a.in_data = 128'(idx);
      if (idx == stop_idx && !stop_sent) begin if_a.stop = 1'b1; stop_sent = 1'b1; end
      if (idx == 100 && !start2_sent) begin if_a.start = 1'b1; start2_sent = 1'b1; end
      @(posedge clk); #1;
      if (en && iv) idx++;
      if (if_a.done) begin done_cnt++; done_at = idx - 1; end
      #1; if_a.start = 1'b0; if_a.stop = 1'b0;
    end
    if_a.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (if_a.done) done_cnt++;
      #1;
    end
  endtask

  // ---------------- vector table for the 4/4/0 instance ----------------
  typedef struct {
    logic en, start, stop, iv;
    logic [15:0] data;
    logic [1:0]  nf;
    logic ov, sof, eof, busy, done;
    logic [1:0]  fc;
    logic [15:0] odata;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic start, input logic stop,
                              input logic iv, input logic [15:0] data, input logic [1:0] nf,
                              input logic ov, input logic sof, input logic eof, input logic busy,
                              input logic done, input logic [1:0] fc, input logic [15:0] odata);
    vec_t v;
    v.en = en; v.start = start; v.stop = stop; v.iv = iv; v.data = data; v.nf = nf;
    v.ov = ov; v.sof = sof; v.eof = eof; v.busy = busy; v.done = done; v.fc = fc;
    v.odata = odata;
    return v;
  endfunction

  // ---------------- random-run reference model state ----------------
  logic        r_en, r_iv, r_start, r_stop, r_rst;
  logic [2:0]  r_nf;
  logic [15:0] r_data;
  bit          m_busy, m_done, m_stop, m_end;
  int          m_acc, m_nf, m_fc, m_pos;
  logic        e_ov, e_sof, e_eof;
  logic [15:0] e_data;

  int d_cnt, d_at;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.enable = 0; if_a.start = 0; if_a.stop = 0; if_a.num_frames = 0;
    if_a.in_valid = 0; if_a.in_data = 0;
    if_b.enable = 0; if_b.start = 0; if_b.stop = 0; if_b.num_frames = 0;
    if_b.in_valid = 0; if_b.in_data = 0;
    if_c.enable = 0; if_c.start = 0; if_c.stop = 0; if_c.num_frames = 0;
    if_c.in_valid = 0; if_c.in_data = 0;
    #1;
    check("reset_a", {if_a.out_valid, if_a.out_sof, if_a.out_eof, if_a.busy, if_a.done,
          if_a.frame_counter, if_a.out_data}, 0);
    check("reset_b", {if_b.out_valid, if_b.busy, if_b.done, if_b.frame_counter, if_b.out_data}, 0);
    check("reset_c", {if_c.out_valid, if_c.busy, if_c.done, if_c.frame_counter, if_c.out_data}, 0);
    repeat (2) @(posedge clk);
    #2; rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // ---- table: continuous wrap, start+stop in IDLE, start while busy, freeze, stop ----
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 20; k++)
      tbl.push_back(mk(1, k == 6, 0, 1, 16'(k + 100), 0, 1, (k % 4) == 0, (k % 4) == 3, 1, 0,
                       2'((k + 1) / 4), 16'(k + 100)));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 16'h55, 0, 0, 0, 0, 1, 0, 1, 0));
    for (int k = 20; k < 24; k++)
      tbl.push_back(mk(1, 0, 0, 1, 16'(k + 100), 0, 1, k == 20, k == 23, k != 23, k == 23,
                       (k == 23) ? 2'd2 : 2'd1, 16'(k + 100)));
    tbl.push_back(mk(1, 0, 0, 1, 16'h77, 0, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 0, 1, 16'h78, 0, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0, 1, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 0, k == 3, 1, 16'(k + 200), 0, 1, k == 0, k == 3, k != 3, k == 3,
                       (k == 3) ? 2'd1 : 2'd0, 16'(k + 200)));
    tbl.push_back(mk(1, 0, 0, 1, 16'h99, 0, 0, 0, 0, 0, 0, 1, 0));
    foreach (tbl[i]) begin
      if_b.enable = tbl[i].en; if_b.start = tbl[i].start; if_b.stop = tbl[i].stop;
      if_b.in_valid = tbl[i].iv; if_b.in_data = tbl[i].data; if_b.num_frames = tbl[i].nf;
      @(posedge clk); #1;
      check($sformatf("tbl[%0d]", i),
            {if_b.out_valid, if_b.out_sof, if_b.out_eof, if_b.busy, if_b.done,
             if_b.frame_counter, if_b.out_data},
            {tbl[i].ov, tbl[i].sof, tbl[i].eof, tbl[i].busy, tbl[i].done, tbl[i].fc,
             tbl[i].odata});
      #1;
    end
    if_b.enable = 0; if_b.start = 0; if_b.stop = 0; if_b.in_valid = 0;

    // ---- default geometry: two-frame run ----
    a_mon = 1'b1;
    a_run(2, 4096, -1, 1'b0, -1, d_cnt, d_at);
    check("s1_out_count", a_k, 4000);
    check("s1_done_count", d_cnt, 1);
    check("s1_done_after", d_at, 4095);
    check("s1_frame_counter", if_a.frame_counter, 2);
    check("s1_idle", if_a.busy, 0);

    // ---- continuous, stop mid second frame, stream keeps flowing afterwards ----
    a_run(0, 4300, 3000, 1'b0, -1, d_cnt, d_at);
    check("s2_out_count", a_k, 4000);
    check("s2_done_count", d_cnt, 1);
    check("s2_done_after", d_at, 4095);
    check("s2_frame_counter", if_a.frame_counter, 2);

    // ---- freeze plus gapped in_valid: same sequence, stretched ----
    a_run(2, 4096, -1, 1'b1, -1, d_cnt, d_at);
    check("s3_out_count", a_k, 4000);
    check("s3_done_count", d_cnt, 1);
    check("s3_done_after", d_at, 4095);
    check("s3_frame_counter", if_a.frame_counter, 2);

    // ---- reset mid-frame, then a fresh one-frame run ----
    a_run(2, 4096, -1, 1'b0, 1234, d_cnt, d_at);
    @(posedge clk); #2; rst_a = 1'b0;
    a_run(1, 2048, -1, 1'b0, -1, d_cnt, d_at);
    check("s4_out_count", a_k, 2000);
    check("s4_done_after", d_at, 2047);
    check("s4_frame_counter", if_a.frame_counter, 1);
    a_mon = 1'b0;

    // ---- randomized run on the 5/3/2 instance ----
    m_busy = 0; m_done = 0; m_stop = 0; m_acc = 0; m_nf = 0; m_fc = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r_en    = ($urandom % 10) != 0;
      r_iv    = ($urandom % 10) < 7;
      r_start = ($urandom % 8) == 0;
      r_stop  = ($urandom % 64) == 0;
      r_rst   = ($urandom % 500) == 0;
      r_nf    = 3'($urandom % 4);
      r_data  = 16'($urandom);
      if_c.enable = r_en; if_c.in_valid = r_iv; if_c.start = r_start; if_c.stop = r_stop;
      if_c.num_frames = r_nf; if_c.in_data = r_data; rst_c = r_rst;
      @(posedge clk);
      e_ov = 0; e_sof = 0; e_eof = 0; e_data = 0; m_end = 0;
      if (r_rst) begin
        m_busy = 0; m_done = 0; m_stop = 0; m_acc = 0; m_fc = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (!m_busy) begin
        if (r_start && r_en) begin
          m_busy = 1; m_acc = 0; m_fc = 0; m_stop = 0; m_nf = int'(r_nf);
        end
      end else begin
        if (r_en && r_iv) begin
          m_pos = m_acc % 5;
          if (m_pos < 3) begin
            e_ov = 1; e_data = r_data; e_sof = (m_pos == 0); e_eof = (m_pos == 2);
          end
          m_acc++;
          if (m_pos == 4) begin
            m_fc = (m_acc / 5) % 8;
            m_end = m_stop || (m_nf != 0 && m_fc == m_nf);
          end
        end
        if (r_stop) m_stop = 1;
        if (m_end) begin m_busy = 0; m_done = 1; end
      end
      #1;
      check($sformatf("rand[%0d]", cyc),
            {if_c.out_valid, if_c.out_sof, if_c.out_eof, if_c.busy, if_c.done,
             if_c.frame_counter, if_c.out_data},
            {e_ov, e_sof, e_eof, m_busy, m_done, 3'(m_fc), e_data});
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
